// File: rtl/oqpsk_demodulator_pkg.sv
// Shared types and constants for the OQPSK demodulator.
package oqpsk_demodulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } demod_state_t;

    // Decided bits per component (I or Q) in one output word.
    localparam int BITS_PER_COMPONENT = 32;

endpackage

// File: rtl/oqpsk_bit_collector.sv
// Hard-decision slicer plus LSB-first bit collector for one component (I or Q).
// Bit k of the word is the k-th decision since the last clear; undecided bits stay 0.
module oqpsk_bit_collector
    import oqpsk_demodulator_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                          aclk,
    input  logic                          sresetn,
    input  logic                          decide,
    input  logic [SAMPLE_WIDTH-1:0]       sample,
    input  logic                          clear,
    output logic [BITS_PER_COMPONENT-1:0] word_next
);

    localparam int IW = $clog2(BITS_PER_COMPONENT + 1);

    logic [BITS_PER_COMPONENT-1:0] word_q;
    logic [IW-1:0]                 idx;

    // Word including the decision made this cycle, so a load can capture it directly.
    always_comb begin
        word_next = word_q;
        if (decide && (idx < IW'(BITS_PER_COMPONENT)))
            word_next[idx[IW-2:0]] = ~sample[SAMPLE_WIDTH-1];
    end

    // Store decisions; clear wins so a loaded word never leaks into the next one.
    always_ff @(posedge aclk) begin
        if (!sresetn) begin
            word_q <= '0;
            idx    <= '0;
        end else if (clear) begin
            word_q <= '0;
            idx    <= '0;
        end else if (decide) begin
            word_q <= word_next;
            idx    <= idx + IW'(1);
        end
    end

endmodule

// File: rtl/oqpsk_demodulator.sv
// OQPSK hard-decision demodulator: samples {Q,I} in, 64-bit {Q bits, I bits} words out.
// Optional feature macro: OQPSK_DEMOD_ERR_EN adds the sticky burst_error output.
//
// state | meaning
// IDLE  | waiting for the first beat of a burst (that beat is sample n = 0)
// RUN   | collecting decisions until the final Q decision or an early tlast
// FLUSH | padded partial word loaded with tlast; waiting for it to be accepted
module oqpsk_demodulator
    import oqpsk_demodulator_pkg::*;
#(
    parameter int BURST_SIZE             = 256,
    parameter int SAMPLES_PER_SYMBOL     = 8,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 64
) (
    input  logic                              aclk,
    input  logic                              sresetn,
    input  logic                              s00_axis_tvalid,
    output logic                              s00_axis_tready,
    input  logic                              s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    output logic                              m00_axis_tvalid,
    output logic                              m00_axis_tlast,
    input  logic                              m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata
`ifdef OQPSK_DEMOD_ERR_EN
    ,output logic                             burst_error
`endif
);

    localparam int HW        = C_S00_AXIS_TDATA_WIDTH / 2;
    localparam int PW        = $clog2(SAMPLES_PER_SYMBOL);
    localparam int SW        = $clog2(BURST_SIZE * BITS_PER_COMPONENT + 1);
    localparam int LW        = $clog2(BITS_PER_COMPONENT);
    localparam int WCW       = (BURST_SIZE > 1) ? $clog2(BURST_SIZE) : 1;
    localparam logic [PW-1:0]  HALF_PHASE = PW'(SAMPLES_PER_SYMBOL / 2);
    localparam logic [PW-1:0]  LAST_PHASE = PW'(SAMPLES_PER_SYMBOL - 1);
    localparam logic [SW-1:0]  TOTAL_SYM  = SW'(BURST_SIZE * BITS_PER_COMPONENT);
    localparam logic [WCW-1:0] LAST_WORD  = WCW'(BURST_SIZE - 1);

    demod_state_t state, state_next;

    logic [PW-1:0]  phase;
    logic [SW-1:0]  sym_cnt;
    logic [WCW-1:0] word_cnt;
    logic [BITS_PER_COMPONENT-1:0] i_word, q_word;
    logic beat, i_dec, q_dec, word_load, final_beat, early_tlast, load_out;

    // Counters sit at zero outside RUN, so the first beat in IDLE is naturally n = 0.
    assign beat        = s00_axis_tvalid && s00_axis_tready;
    assign i_dec       = beat && (phase == HALF_PHASE);
    assign q_dec       = beat && (phase == '0) && (sym_cnt != '0);
    assign word_load   = q_dec && (sym_cnt[LW-1:0] == '0);
    assign final_beat  = q_dec && (sym_cnt == TOTAL_SYM);
    assign early_tlast = beat && s00_axis_tlast && !final_beat;
    assign load_out    = word_load || early_tlast;

    oqpsk_bit_collector #(.SAMPLE_WIDTH(HW)) u_i_collector (
        .aclk      (aclk),
        .sresetn   (sresetn),
        .decide    (i_dec),
        .sample    (s00_axis_tdata[HW-1:0]),
        .clear     (load_out),
        .word_next (i_word)
    );

    oqpsk_bit_collector #(.SAMPLE_WIDTH(C_S00_AXIS_TDATA_WIDTH - HW)) u_q_collector (
        .aclk      (aclk),
        .sresetn   (sresetn),
        .decide    (q_dec),
        .sample    (s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:HW]),
        .clear     (load_out),
        .word_next (q_word)
    );

    // State register.
    always_ff @(posedge aclk) begin
        if (!sresetn) state <= IDLE;
        else          state <= state_next;
    end

    // Next-state decode; a tlast on the very first beat is an early tlast too.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat) state_next = early_tlast ? FLUSH : RUN;
            RUN:     if (final_beat) state_next = IDLE;
                     else if (early_tlast) state_next = FLUSH;
            FLUSH:   if (m00_axis_tvalid && m00_axis_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Input back-pressure: blocked while the padded word drains.
    always_comb begin
        s00_axis_tready = !m00_axis_tvalid || m00_axis_tready;
        if (state == FLUSH) s00_axis_tready = 1'b0;
    end

    // Sample phase and symbol counters, restarted at burst end.
    always_ff @(posedge aclk) begin
        if (!sresetn) begin
            phase   <= '0;
            sym_cnt <= '0;
        end else if (beat) begin
            if (final_beat || early_tlast) begin
                phase   <= '0;
                sym_cnt <= '0;
            end else if (phase == LAST_PHASE) begin
                phase   <= '0;
                sym_cnt <= sym_cnt + SW'(1);
            end else begin
                phase <= phase + PW'(1);
            end
        end
    end

    // Output word register; a load only happens on a beat, so held data is never overwritten.
    always_ff @(posedge aclk) begin
        if (!sresetn) begin
            m00_axis_tvalid <= 1'b0;
            m00_axis_tlast  <= 1'b0;
            m00_axis_tdata  <= '0;
            word_cnt        <= '0;
        end else if (load_out) begin
            m00_axis_tvalid <= 1'b1;
            m00_axis_tdata  <= C_M00_AXIS_TDATA_WIDTH'({q_word, i_word});
            if (early_tlast || (word_cnt == LAST_WORD)) begin
                m00_axis_tlast <= 1'b1;
                word_cnt       <= '0;
            end else begin
                m00_axis_tlast <= 1'b0;
                word_cnt       <= word_cnt + WCW'(1);
            end
        end else if (m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
        end
    end

`ifdef OQPSK_DEMOD_ERR_EN
    // Sticky framing error; a new error in the same cycle wins over the restart clear.
    always_ff @(posedge aclk) begin
        if (!sresetn)
            burst_error <= 1'b0;
        else if (early_tlast || (final_beat && !s00_axis_tlast))
            burst_error <= 1'b1;
        else if ((state == IDLE) && beat)
            burst_error <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_oqpsk_demodulator.sv
// Scoreboard bench for oqpsk_demodulator (SPS = 8, BURST = 2).
// Build with OQPSK_DEMOD_ERR_EN defined to also check burst_error.
module tb_oqpsk_demodulator;

    localparam int SPS   = 8;
    localparam int BURST = 2;
    localparam int NS    = BURST * 32 * SPS + 1;

    logic        aclk = 1'b0;
    logic        sresetn;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [63:0] m_tdata;
`ifdef OQPSK_DEMOD_ERR_EN
    logic        burst_error;
`endif

    oqpsk_demodulator #(
        .BURST_SIZE(BURST), .SAMPLES_PER_SYMBOL(SPS),
        .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(64)
    ) dut (
        .aclk(aclk), .sresetn(sresetn),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tready(s_tready),
        .s00_axis_tlast(s_tlast), .s00_axis_tdata(s_tdata),
        .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast),
        .m00_axis_tready(m_tready), .m00_axis_tdata(m_tdata)
`ifdef OQPSK_DEMOD_ERR_EN
        ,.burst_error(burst_error)
`endif
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Modulator model: I symbol k spans samples [k*SPS, (k+1)*SPS), Q lags by SPS/2.
    function automatic logic [31:0] samp(input logic [63:0] w0, input logic [63:0] w1, input int n);
        logic [63:0] w;
        logic        ib, qb;
        int          k;
        ib = 1'b0;
        qb = 1'b0;
        k = n / SPS;
        if (k < 64) begin
            w  = (k < 32) ? w0 : w1;
            ib = w[k % 32];
        end
        if (n >= SPS / 2) begin
            k = (n - SPS / 2) / SPS;
            if (k < 64) begin
                w  = (k < 32) ? w0 : w1;
                qb = w[32 + k % 32];
            end
        end
        return {(qb ? 16'h03E8 : 16'hFC18), (ib ? 16'h03E8 : 16'hFC18)};
    endfunction

    function automatic logic [31:0] low_mask(input int nbits);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < nbits && i < 32; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic exp_t mk(input logic [63:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat was taken.
    task automatic send_beat(input logic [31:0] d, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        for (int t = 0; ; t++) begin
            @(negedge aclk);
            if (s_tready) break;
            if (t > 200) begin
                $display("FAIL send_timeout actual=stalled required=beat");
                errors++;
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "input stalled");
            end
            @(posedge aclk); #1;
        end
        @(posedge aclk); #1;
    endtask

    task automatic send_seq(input logic [63:0] w0, input logic [63:0] w1, input bit use_const,
                            input logic [31:0] cval, input int count, input int last_n);
        for (int n = 0; n < count; n++)
            send_beat(use_const ? cval : samp(w0, w1, n), n == last_n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(posedge aclk); #1;
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain actual=%0d_pending required=0", name, sb.size());
            sb.delete();
        end
        repeat (4) @(posedge aclk);
        #1;
    endtask

    task automatic chk_err(input string name, input logic req);
`ifdef OQPSK_DEMOD_ERR_EN
        chk(name, 64'(burst_error), 64'(req));
`else
        if (name.len() == 0 && req) $display("unused");
`endif
    endtask

    // Monitor: drives m_tready (with optional stall), compares accepted words and held words.
    initial begin : monitor
        exp_t e;
        m_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            if (stall_left > 0 && m_tvalid) begin
                m_tready = 1'b0;
                stall_left--;
            end else begin
                m_tready = 1'b1;
            end
            @(negedge aclk);
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word actual=%h required=none", m_tdata);
                end else begin
                    e = sb.pop_front();
                    chk("word_data", m_tdata, e.data);
                    chk("word_last", 64'(m_tlast), 64'(e.last));
                end
            end else if (m_tvalid && !m_tready) begin
                if (sb.size() != 0) begin
                    chk("held_data", m_tdata, sb[0].data);
                    chk("held_last", 64'(m_tlast), 64'(sb[0].last));
                end
                chk("stall_s_tready", 64'(s_tready), 64'd0);
            end
        end
    end

    localparam logic [63:0] PA0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] PA1 = 64'hFEDCBA9876543210;
    localparam logic [63:0] PB0 = 64'hDEADBEEFCAFEF00D;
    localparam logic [63:0] PB1 = 64'h0F0F0F0FA5A5A5A5;

    initial begin : main
        logic [31:0] iw, qw;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        sresetn  = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("reset_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_tlast", 64'(m_tlast), 64'd0);
        chk("reset_tdata", m_tdata, 64'd0);
        chk("reset_s_tready", 64'(s_tready), 64'd1);
        chk_err("reset_burst_error", 1'b0);
        @(posedge aclk); #1;
        sresetn = 1'b1;

        // Nominal burst, tlast on the final sample.
        sb.push_back(mk(PA0, 1'b0));
        sb.push_back(mk(PA1, 1'b1));
        send_seq(PA0, PA1, 1'b0, '0, NS, NS - 1);
        drain("nominal");
        chk_err("nominal_burst_error", 1'b0);

        // Same burst with a 20-cycle output stall on the first word.
        stall_left = 20;
        sb.push_back(mk(PA0, 1'b0));
        sb.push_back(mk(PA1, 1'b1));
        send_seq(PA0, PA1, 1'b0, '0, NS, NS - 1);
        drain("stall");

        // Early tlast on sample n = 100: 13 I decisions, 12 Q decisions.
        iw = PA0[31:0] & low_mask((100 - SPS / 2) / SPS + 1);
        qw = PA0[63:32] & low_mask(100 / SPS);
        sb.push_back(mk({qw, iw}, 1'b1));
        send_seq(PA0, PA1, 1'b0, '0, 101, 100);
        drain("early_tlast");
        chk("early_expected_word", {qw, iw}, 64'h00000567_00000DEF);
        chk_err("early_burst_error", 1'b1);

        // Constant inputs; the zero burst omits tlast, which must still complete normally.
        sb.push_back(mk(64'hFFFFFFFF_FFFFFFFF, 1'b0));
        sb.push_back(mk(64'hFFFFFFFF_FFFFFFFF, 1'b1));
        send_seq('0, '0, 1'b1, 32'h0000_0000, NS, -1);
        drain("all_zero");
        chk_err("missing_tlast_burst_error", 1'b1);
        sb.push_back(mk(64'h0, 1'b0));
        sb.push_back(mk(64'h0, 1'b1));
        send_seq('0, '0, 1'b1, 32'h8000_8000, NS, NS - 1);
        drain("all_neg");
        chk_err("cleared_burst_error", 1'b0);

        // Reset at sample 300; the first word was already complete and delivered at n = 256.
        sb.push_back(mk(PA0, 1'b0));
        send_seq(PA0, PA1, 1'b0, '0, 300, -1);
        drain("pre_reset");
        sresetn = 1'b0;
        @(posedge aclk); #1;
        sresetn = 1'b1;
        @(negedge aclk);
        chk("post_reset_tvalid", 64'(m_tvalid), 64'd0);
        chk("post_reset_tdata", m_tdata, 64'd0);
        @(posedge aclk); #1;
        sb.push_back(mk(PB0, 1'b0));
        sb.push_back(mk(PB1, 1'b1));
        send_seq(PB0, PB1, 1'b0, '0, NS, NS - 1);
        drain("after_reset");

        // Two bursts back-to-back with no idle gap.
        sb.push_back(mk(PA0, 1'b0));
        sb.push_back(mk(PA1, 1'b1));
        sb.push_back(mk(PB0, 1'b0));
        sb.push_back(mk(PB1, 1'b1));
        for (int n = 0; n < NS; n++) send_beat(samp(PA0, PA1, n), n == NS - 1);
        for (int n = 0; n < NS; n++) send_beat(samp(PB0, PB1, n), n == NS - 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        drain("back_to_back");
        chk_err("b2b_burst_error", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oqpsk_demodulator.md
OQPSK_DEMODULATOR -- requirements
Module: oqpsk_demodulator

Interface
REQ-001 SHALL have parameter BURST_SIZE, default 256: 64-bit words per burst.
REQ-002 SHALL have parameter SAMPLES_PER_SYMBOL, default 8: samples per symbol; even, >=2.
REQ-003 SHALL have parameter C_S00_AXIS_TDATA_WIDTH, default 32: input sample width, {Q[31:16],I[15:0]}, signed.
REQ-004 SHALL have parameter C_M00_AXIS_TDATA_WIDTH, default 64: output word width, {Q bits[63:32], I bits[31:0]}.
REQ-005 SHALL have port aclk, input, 1: clock; all logic on its rising edge.
REQ-006 SHALL have port sresetn, input, 1: reset; synchronous, active-low.
REQ-007 SHALL have ports s00_axis_tvalid/tready/tlast (in/out/in, 1) and s00_axis_tdata (in, 32): sample stream.
REQ-008 SHALL have ports m00_axis_tvalid/tlast (out, 1), m00_axis_tready (in, 1) and m00_axis_tdata (out, 64): word stream.

Function
REQ-009 SHALL accept a sample only on s00_axis_tvalid && s00_axis_tready (beat).
REQ-010 SHALL drive s00_axis_tready = !m00_axis_tvalid || m00_axis_tready, except in FLUSH, where it is 0.
REQ-011 SHALL run FSM IDLE -> RUN on first beat; RUN -> IDLE after the final Q decision; RUN -> FLUSH on early tlast; FLUSH -> IDLE once the padded word is accepted.
REQ-012 SHALL keep sample index n (0-based) per burst: phase = n mod SAMPLES_PER_SYMBOL, with a symbol counter.
REQ-013 SHALL decide an I bit on the beat where phase == SAMPLES_PER_SYMBOL/2.
REQ-014 SHALL decide a Q bit on the beat where phase == 0 and n >= SAMPLES_PER_SYMBOL; this removes the half-symbol offset.
REQ-015 SHALL set bit = 1 when the sample is >= 0 (sign bit clear), else 0.
REQ-016 SHALL shift bits LSB-first: bit k of a word is the k-th decision of that component within the word.
REQ-017 SHALL load the output register, set m00_axis_tvalid = 1, and clear both shift registers on the beat delivering the 32nd Q bit of a word.
REQ-018 SHALL keep m00_axis_tdata/tlast stable while tvalid && !tready, and clear tvalid on acceptance unless a new word loads in the same cycle.
REQ-019 SHALL count emitted words 0..BURST_SIZE-1 and assert m00_axis_tlast with word BURST_SIZE-1, then reset the count to 0.
REQ-020 SHALL treat the burst as complete at sample n = BURST_SIZE*32*SAMPLES_PER_SYMBOL (the final Q decision); the total is that value + 1 samples.
REQ-021 SHALL, if s00_axis_tlast arrives before n reaches the completion value, enter FLUSH, emit the partial word zero-padded in its undecided upper bits with tlast = 1, then return to IDLE.
REQ-022 SHALL, if tlast and the final sample coincide, treat the burst as normal completion; a missing tlast on the final sample is ignored (the burst still completes).
REQ-023 SHALL ignore input beats after completion until IDLE restarts on the next beat; the next beat is n = 0.

Reset
REQ-024 SHALL, in reset, set m00_axis_tvalid = 0, m00_axis_tlast = 0, m00_axis_tdata = 0, FSM = IDLE, and all counters and shift registers = 0.
REQ-025 SHALL, on reset mid-burst, discard partial data; the first beat after reset is n = 0.

Configuration
REQ-026 SHALL, when OQPSK_DEMOD_ERR_EN is defined, add output burst_error (1 bit, reset 0), sticky-high on early tlast or a missing tlast at completion, cleared on the next IDLE -> RUN transition.
REQ-027 SHALL, when OQPSK_DEMOD_ERR_EN is undefined, have no burst_error port and no related logic.

Structure
REQ-028 SHALL define demod_state_t (IDLE, RUN, FLUSH) and the bits-per-component constant 32 in the shared typedefs package.
REQ-029 SHALL place the I/Q slicer-plus-shift-register in one sub-module, oqpsk_bit_collector, instantiated once per component.

Verification
REQ-030 SHALL test: SPS=8, BURST=2, modulated pattern 0x0123456789ABCDEF then 0xFEDCBA9876543210 (513 samples) -> exactly these 2 words, tlast on word 2 only.
REQ-031 SHALL test: same stimulus with m00_axis_tready low for 20 cycles at word 1 -> word held stable, s00_axis_tready = 0 while stalled, no data loss.
REQ-032 SHALL test: tlast on sample 100 of burst -> one word with tlast, decided bits correct, upper bits 0, burst_error = 1 when the macro is on.
REQ-033 SHALL test: all samples = 0x0000_0000 -> word 0xFFFFFFFF_FFFFFFFF; all 0x8000_8000 -> word 0.
REQ-034 SHALL test: sresetn low for 1 cycle at sample 300, then a clean burst -> only clean-burst words emitted, tlast correct.
REQ-035 SHALL test: two bursts back-to-back with no gap -> 4 words, tlast on words 2 and 4, and the second burst starts at n = 0.
